// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_pkg
// Purpose  : Shared types, write-mode constants and the parity helper for
//            the polynomial coefficient dual-port RAM.
// Revision : 1.0  initial release
// ============================================================================
package dpram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } zeroize_state_e;

    localparam int c_READ_FIRST  = 0;
    localparam int c_WRITE_FIRST = 1;

    // Callers zero-extend to this width; zero padding leaves the parity unchanged.
    localparam int c_PARITY_MAX_W = 64;

    // Returns the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [c_PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_zeroize_fsm.sv
`default_nettype none
// ============================================================================
// Module   : dpram_zeroize_fsm
// Purpose  : Sequences a full-array wipe, two words per cycle, and exposes
//            the clear index/strobe that the top level muxes onto both ports.
// Revision : 1.0  initial release
// ============================================================================
module dpram_zeroize_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              zeroize_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              clr_en_o,
    output logic [ADDR_W-2:0] clr_idx_o
);

    localparam logic [1:0]        c_ST_IDLE  = IDLE;
    localparam logic [1:0]        c_ST_CLEAR = CLEAR;
    localparam logic [1:0]        c_ST_DONE  = DONE;
    localparam logic [ADDR_W-2:0] c_CNT_LAST = '1;

    logic [1:0]        r_state_q;
    logic [1:0]        w_state_d;
    logic [ADDR_W-2:0] r_cnt_q;
    logic [ADDR_W-2:0] w_cnt_d;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (zeroize_i) begin
                    w_state_d = c_ST_CLEAR;
                    w_cnt_d   = '0;
                end
            end
            c_ST_CLEAR: begin
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= c_ST_IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign busy_o    = (r_state_q == c_ST_CLEAR);
    assign done_o    = (r_state_q == c_ST_DONE);
    assign clr_en_o  = (r_state_q == c_ST_CLEAR);
    assign clr_idx_o = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/dual_port_poly_ram.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_poly_ram
// Purpose  : True dual-port coefficient RAM with 1-cycle registered reads,
//            port-A-wins write collisions and a built-in zeroize engine.
//            Optional per-word even parity: define DPRAM_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module dual_port_poly_ram
    import dpram_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 8,
    parameter int WRITE_FIRST = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic              rvalid_a_o,
    input  logic              en_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic              rvalid_b_o,
    input  logic              zeroize_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              collision_o,
    output logic              perr_a_o,
    output logic              perr_b_o
);

`ifdef DPRAM_PARITY_EN
    localparam int c_MEM_W = DATA_W + 1;
`else
    localparam int c_MEM_W = DATA_W;
`endif
    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [c_MEM_W-1:0] r_mem [c_DEPTH];

    logic              w_busy;
    logic              w_clr_en;
    logic [ADDR_W-2:0] w_clr_idx;

    dpram_zeroize_fsm #(
        .ADDR_W (ADDR_W)
    ) u_zeroize (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .zeroize_i (zeroize_i),
        .busy_o    (w_busy),
        .done_o    (done_o),
        .clr_en_o  (w_clr_en),
        .clr_idx_o (w_clr_idx)
    );

    logic               w_wr_a;
    logic               w_wr_b;
    logic [ADDR_W-1:0]  w_addr_a;
    logic [ADDR_W-1:0]  w_addr_b;
    logic [c_MEM_W-1:0] w_wword_a;
    logic [c_MEM_W-1:0] w_wword_b;
    logic               w_coll;
    logic               w_rd_a;
    logic               w_rd_b;
    logic [c_MEM_W-1:0] w_rword_a;
    logic [c_MEM_W-1:0] w_rword_b;

    logic [DATA_W-1:0]  r_rdata_a_q, w_rdata_a_d;
    logic [DATA_W-1:0]  r_rdata_b_q, w_rdata_b_d;
    logic               r_rvalid_a_q, w_rvalid_a_d;
    logic               r_rvalid_b_q, w_rvalid_b_d;
    logic               r_coll_q, w_coll_d;

    always_comb begin
        w_wr_a    = w_busy ? w_clr_en : (en_a_i & we_a_i);
        w_addr_a  = w_busy ? {w_clr_idx, 1'b0} : addr_a_i;
        w_addr_b  = w_busy ? {w_clr_idx, 1'b1} : addr_b_i;
`ifdef DPRAM_PARITY_EN
        w_wword_a = w_busy ? '0 : {even_parity(c_PARITY_MAX_W'(wdata_a_i)), wdata_a_i};
        w_wword_b = w_busy ? '0 : {even_parity(c_PARITY_MAX_W'(wdata_b_i)), wdata_b_i};
`else
        w_wword_a = w_busy ? '0 : wdata_a_i;
        w_wword_b = w_busy ? '0 : wdata_b_i;
`endif
        // Port A wins a same-address double write; B's write is dropped.
        w_coll    = !w_busy & en_a_i & we_a_i & en_b_i & we_b_i & (addr_a_i == addr_b_i);
        w_wr_b    = (w_busy ? w_clr_en : (en_b_i & we_b_i)) & !w_coll;

        w_rd_a    = en_a_i & !we_a_i & !w_busy;
        w_rd_b    = en_b_i & !we_b_i & !w_busy;

        w_rword_a = r_mem[addr_a_i];
        w_rword_b = r_mem[addr_b_i];
        if (WRITE_FIRST == c_WRITE_FIRST) begin
            if (w_wr_b && (w_addr_b == addr_a_i)) begin
                w_rword_a = w_wword_b;
            end
            if (w_wr_a && (w_addr_a == addr_b_i)) begin
                w_rword_b = w_wword_a;
            end
        end

        w_rdata_a_d  = w_rd_a ? w_rword_a[DATA_W-1:0] : r_rdata_a_q;
        w_rdata_b_d  = w_rd_b ? w_rword_b[DATA_W-1:0] : r_rdata_b_q;
        w_rvalid_a_d = w_rd_a;
        w_rvalid_b_d = w_rd_b;
        w_coll_d     = w_coll;
    end

    // Storage is never reset so secrets survive only until an explicit zeroize.
    always_ff @(posedge clk_i) begin
        if (w_wr_a) begin
            r_mem[w_addr_a] <= w_wword_a;
        end
        if (w_wr_b) begin
            r_mem[w_addr_b] <= w_wword_b;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata_a_q  <= '0;
            r_rdata_b_q  <= '0;
            r_rvalid_a_q <= 1'b0;
            r_rvalid_b_q <= 1'b0;
            r_coll_q     <= 1'b0;
        end else begin
            r_rdata_a_q  <= w_rdata_a_d;
            r_rdata_b_q  <= w_rdata_b_d;
            r_rvalid_a_q <= w_rvalid_a_d;
            r_rvalid_b_q <= w_rvalid_b_d;
            r_coll_q     <= w_coll_d;
        end
    end

`ifdef DPRAM_PARITY_EN
    logic r_perr_a_q, w_perr_a_d;
    logic r_perr_b_q, w_perr_b_d;

    always_comb begin
        w_perr_a_d = w_rd_a &
            (even_parity(c_PARITY_MAX_W'(w_rword_a[DATA_W-1:0])) != w_rword_a[DATA_W]);
        w_perr_b_d = w_rd_b &
            (even_parity(c_PARITY_MAX_W'(w_rword_b[DATA_W-1:0])) != w_rword_b[DATA_W]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perr_a_q <= 1'b0;
            r_perr_b_q <= 1'b0;
        end else begin
            r_perr_a_q <= w_perr_a_d;
            r_perr_b_q <= w_perr_b_d;
        end
    end

    assign perr_a_o = r_perr_a_q;
    assign perr_b_o = r_perr_b_q;
`else
    assign perr_a_o = 1'b0;
    assign perr_b_o = 1'b0;
`endif

    assign rdata_a_o   = r_rdata_a_q;
    assign rdata_b_o   = r_rdata_b_q;
    assign rvalid_a_o  = r_rvalid_a_q;
    assign rvalid_b_o  = r_rvalid_b_q;
    assign busy_o      = w_busy;
    assign collision_o = r_coll_q;

endmodule
`default_nettype wire
